// File: rtl/audio_readmem_i2s.sv
// audio_readmem_i2s: per-voice line-cache sample fetcher plus I2S transmitter; cache hits enabled by AUDIO_READMEM_CACHE_EN
module audio_readmem_i2s #(
   parameter int MCLK_HALF = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [2:0]  current_channel,
   input  logic        mem_request,
   input  logic [25:0] mem_address,
   output logic        mem_valid,
   output logic [15:0] mem_data,
   output logic        sdram_request,
   input  logic        sdram_ready,
   output logic [25:0] sdram_address,
   input  logic        sdram_rvalid,
   input  logic [25:0] sdram_raddress,
   input  logic [31:0] sdram_rdata,
   input  logic        sdram_complete,
   input  logic [15:0] sample_left,
   input  logic [15:0] sample_right,
   output logic        sample_strobe,
   output logic        AUD_MCLK,
   output logic        AUD_BCLK,
   output logic        AUD_LRCLK,
   output logic        AUD_DACDAT
);
   typedef enum logic [2:0] {IDLE, LOOKUP, RESPOND, REQ, FILL} state_t;
   localparam int FRAME = 512 * MCLK_HALF;
   localparam int CW = $clog2(FRAME);
   localparam int MB = $clog2(MCLK_HALF);
`ifdef AUDIO_READMEM_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   state_t state_q, state_d;
   logic [2:0] ch_q, ch_d;
   logic [25:0] addr_q, addr_d;
   logic [31:0] word_q, word_d;
   logic [7:0] valid_q, valid_d;
   logic filled_q, filled_d;
   logic [20:0] tag_q [8];
   logic [31:0] line_q [128];
   logic wr_en, tag_we, hit;
   logic unused_raddr;

   assign unused_raddr = ^{sdram_raddress[25:6], sdram_raddress[1:0]};
   // without the cache only the line just filled may answer
   assign hit = (CACHE || filled_q) && valid_q[ch_q] && tag_q[ch_q] == addr_q[25:5];
   assign mem_valid = state_q == RESPOND;
   assign mem_data = addr_q[0] ? word_q[31:16] : word_q[15:0];
   assign sdram_request = state_q == REQ;
   assign sdram_address = {addr_q[24:5], 6'b0};

   always_comb begin
      state_d = state_q;
      ch_d = ch_q;
      addr_d = addr_q;
      word_d = word_q;
      valid_d = valid_q;
      filled_d = filled_q;
      wr_en = 1'b0;
      tag_we = 1'b0;
      case (state_q)
         IDLE: if (mem_request) begin
            ch_d = current_channel;
            addr_d = mem_address;
            state_d = LOOKUP;
         end
         LOOKUP: begin
            word_d = line_q[{ch_q, addr_q[4:1]}];
            filled_d = 1'b0;
            if (hit) state_d = RESPOND;
            else begin
               valid_d[ch_q] = 1'b0;
               state_d = REQ;
            end
         end
         RESPOND: state_d = IDLE;
         REQ: if (sdram_ready) state_d = FILL;
         FILL: begin
            wr_en = sdram_rvalid;
            if (sdram_complete) begin
               valid_d[ch_q] = 1'b1;
               tag_we = 1'b1;
               filled_d = 1'b1;
               state_d = LOOKUP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         ch_q <= '0;
         addr_q <= '0;
         word_q <= '0;
         valid_q <= '0;
         filled_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q <= ch_d;
         addr_q <= addr_d;
         word_q <= word_d;
         valid_q <= valid_d;
         filled_q <= filled_d;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en && !reset) line_q[{ch_q, sdram_raddress[5:2]}] <= sdram_rdata;
      if (tag_we && !reset) tag_q[ch_q] <= addr_q[25:5];
   end

   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0] left_q, left_d, right_q, right_d, smp;
   logic dac_q, dac_d;
   logic [5:0] slot_d;
   logic [3:0] k;

   // DACDAT is registered from the next counter value so it tracks cnt_q glitch-free
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      sample_strobe = cnt_q == CW'(FRAME - 1);
      left_d = sample_strobe ? sample_left : left_q;
      right_d = sample_strobe ? sample_right : right_q;
      slot_d = cnt_d[CW-1 -: 6];
      smp = slot_d[5] ? right_q : left_q;
      k = 4'd0 - slot_d[3:0];
      dac_d = slot_d[4:0] != 5'd0 && slot_d[4:0] <= 5'd16 && smp[k];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
         left_q <= '0;
         right_q <= '0;
         dac_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         left_q <= left_d;
         right_q <= right_d;
         dac_q <= dac_d;
      end
   end

   assign AUD_MCLK = cnt_q[MB];
   assign AUD_BCLK = cnt_q[MB+2];
   assign AUD_LRCLK = cnt_q[CW-1];
   assign AUD_DACDAT = dac_q;
endmodule

// File: tb/tb_audio_readmem_i2s.sv
// tb_audio_readmem_i2s: table-driven fetch requests with a data scoreboard, SDRAM burst responder and I2S frame checks
module tb_audio_readmem_i2s;
`ifdef AUDIO_READMEM_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif
   logic clock = 1'b0, reset = 1'b1;
   logic [2:0] current_channel = '0;
   logic mem_request = 1'b0;
   logic [25:0] mem_address = '0;
   logic mem_valid;
   logic [15:0] mem_data;
   logic sdram_request, sdram_ready = 1'b0;
   logic [25:0] sdram_address;
   logic sdram_rvalid = 1'b0, sdram_complete = 1'b0;
   logic [25:0] sdram_raddress = '0;
   logic [31:0] sdram_rdata = '0;
   logic [15:0] sample_left = 16'h8001, sample_right = 16'h7FFE;
   logic sample_strobe, AUD_MCLK, AUD_BCLK, AUD_LRCLK, AUD_DACDAT;

   audio_readmem_i2s dut (
      .clock(clock), .reset(reset), .current_channel(current_channel), .mem_request(mem_request),
      .mem_address(mem_address), .mem_valid(mem_valid), .mem_data(mem_data), .sdram_request(sdram_request),
      .sdram_ready(sdram_ready), .sdram_address(sdram_address), .sdram_rvalid(sdram_rvalid),
      .sdram_raddress(sdram_raddress), .sdram_rdata(sdram_rdata), .sdram_complete(sdram_complete),
      .sample_left(sample_left), .sample_right(sample_right), .sample_strobe(sample_strobe),
      .AUD_MCLK(AUD_MCLK), .AUD_BCLK(AUD_BCLK), .AUD_LRCLK(AUD_LRCLK), .AUD_DACDAT(AUD_DACDAT)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0, errors = 0;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [25:0] b);
      logic [31:0] i;
      i = {8'b0, b[25:2]};
      return i * 32'h00010001 + 32'h11110000;
   endfunction

   function automatic logic [15:0] exp_half(input logic [25:0] a);
      logic [31:0] w;
      w = mem_word({a[24:1], 2'b00});
      return a[0] ? w[31:16] : w[15:0];
   endfunction

   function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r);
      logic [63:0] v;
      logic [15:0] w;
      int p;
      v = '0;
      for (int s = 0; s < 64; s++) begin
         p = s % 32;
         w = s < 32 ? l : r;
         if (p >= 1 && p <= 16) v[s] = w[16 - p];
      end
      return v;
   endfunction

   typedef struct {logic [15:0] data; bit hit; int t0;} exp_t;
   exp_t sb[$];
   int valid_cnt = 0;

   int wait_cnt = 0, nbeat = 16, bursts = 0, req_cycles = 0, comp_cyc = 0;
   bit busy = 0, rev = 0, late = 0, req_bad = 0;
   logic [25:0] base = '0, last_addr = '0, first_addr = '0;

   initial forever begin
      @(negedge clock);
      sdram_rvalid = 1'b0;
      sdram_complete = 1'b0;
      sdram_ready = 1'b0;
      if (busy) begin
         if (sdram_request) req_bad = 1;
         if (nbeat < 16) begin
            sdram_raddress = base + 26'((rev ? 15 - nbeat : nbeat) * 4);
            sdram_rdata = mem_word(sdram_raddress);
            sdram_rvalid = 1'b1;
            nbeat++;
            if (nbeat == 16 && !late) begin
               sdram_complete = 1'b1;
               busy = 0;
               comp_cyc = cyc;
            end
         end else begin
            sdram_complete = 1'b1;
            busy = 0;
            comp_cyc = cyc;
         end
      end else if (sdram_request) begin
         if (req_cycles == 0) first_addr = sdram_address;
         else if (sdram_address != first_addr) req_bad = 1;
         req_cycles++;
         if (wait_cnt > 0) wait_cnt--;
         else begin
            sdram_ready = 1'b1;
            base = sdram_address;
            last_addr = sdram_address;
            bursts++;
            busy = 1;
            nbeat = 0;
         end
      end
   end

   initial forever begin
      exp_t e;
      @(negedge clock);
      if (mem_valid === 1'b1) begin
         valid_cnt++;
         if (sb.size() == 0) chk("spurious_valid", 1, 0);
         else begin
            e = sb.pop_front();
            chk("mem_data", mem_data, e.data);
            chk("valid_cycle", cyc, e.hit ? e.t0 + 2 : comp_cyc + 2);
         end
      end
   end

   task automatic run_req(input logic [2:0] ch, input logic [25:0] a, input int wt, input bit rv,
                          input bit lt, input bit hold, input bit hit);
      int b0;
      bit got;
      @(negedge clock);
      b0 = bursts;
      wait_cnt = wt;
      rev = rv;
      late = lt;
      req_cycles = 0;
      req_bad = 0;
      sb.push_back('{exp_half(a), hit, cyc});
      current_channel = ch;
      mem_address = a;
      mem_request = 1'b1;
      got = 0;
      for (int n = 0; n < 200 && !got; n++) begin
         @(negedge clock);
         got = mem_valid;
      end
      if (hold) @(negedge clock);
      mem_request = 1'b0;
      chk("valid_seen", got, 1);
      if (!got) sb.delete();
      repeat (4) @(negedge clock);
      chk("burst_count", bursts - b0, hit ? 0 : 1);
      chk("req_cycles", req_cycles, hit ? 0 : wt + 1);
      chk("req_stable", req_bad, 0);
      if (!hit) chk("sdram_addr", last_addr, {a[24:5], 6'b0});
   endtask

   typedef struct {logic [2:0] ch; logic [25:0] a; int wt; bit rv, lt, hold, hit;} vec_t;
   vec_t tbl [13];

   initial begin
      int v0;
      bit seen;
      tbl[0]  = '{3'd0, 26'h0000040, 0,  0, 0, 0, 0};
      tbl[1]  = '{3'd0, 26'h0000041, 0,  0, 0, 0, 1};
      tbl[2]  = '{3'd1, 26'h0000040, 10, 1, 0, 0, 0};
      tbl[3]  = '{3'd0, 26'h0000047, 0,  0, 0, 0, 1};
      tbl[4]  = '{3'd1, 26'h000005F, 0,  0, 0, 1, 1};
      tbl[5]  = '{3'd2, 26'h1234567, 3,  0, 1, 0, 0};
      tbl[6]  = '{3'd2, 26'h1234566, 0,  0, 0, 0, 1};
      tbl[7]  = '{3'd0, 26'h0000060, 0,  1, 0, 0, 0};
      tbl[8]  = '{3'd0, 26'h0000040, 0,  0, 1, 0, 0};
      tbl[9]  = '{3'd7, 26'h3FFFFFF, 0,  0, 1, 0, 0};
      tbl[10] = '{3'd7, 26'h1FFFFFF, 0,  1, 0, 0, 0};
      tbl[11] = '{3'd7, 26'h1FFFFE0, 0,  0, 0, 1, 1};
      tbl[12] = '{3'd3, 26'h0000020, 2,  0, 0, 0, 0};
      repeat (3) @(negedge clock);
      chk("reset_outputs", {mem_valid, mem_data, sdram_request, sdram_address, sample_strobe,
                            AUD_MCLK, AUD_BCLK, AUD_LRCLK, AUD_DACDAT}, 0);
      reset = 1'b0;
      fork
         begin : i2s
            logic pm, pb, pd;
            int lm, lb, mmin, mmax, bmin, bmax, viol, phase_bad, f, s;
            int nrise [3];
            logic [63:0] dat [3], lr [3];
            int strobes[$];
            pm = 0; pb = 0; pd = 0; lm = 0; lb = 0; viol = 0; phase_bad = 0;
            mmin = 1000000; mmax = 0; bmin = 1000000; bmax = 0;
            for (int j = 0; j < 3; j++) begin nrise[j] = 0; dat[j] = '0; lr[j] = '0; end
            for (int i = 1; i <= 6200; i++) begin
               @(negedge clock);
               if (i == 3000) begin sample_left = 16'h1234; sample_right = 16'h4321; end
               if (sample_strobe) strobes.push_back(i);
               f = i / 2048;
               s = (i % 2048) / 32;
               if (i % 2048 == 0 && (AUD_MCLK || AUD_BCLK || AUD_LRCLK)) phase_bad++;
               if (AUD_MCLK && !pm) begin
                  if (lm > 0) begin mmin = i - lm < mmin ? i - lm : mmin; mmax = i - lm > mmax ? i - lm : mmax; end
                  lm = i;
               end
               if (AUD_BCLK && !pb) begin
                  if (lb > 0) begin bmin = i - lb < bmin ? i - lb : bmin; bmax = i - lb > bmax ? i - lb : bmax; end
                  lb = i;
                  if (f < 3) begin dat[f][s] = AUD_DACDAT; lr[f][s] = AUD_LRCLK; nrise[f]++; end
               end
               if (AUD_DACDAT != pd && !(pb && !AUD_BCLK)) viol++;
               pm = AUD_MCLK; pb = AUD_BCLK; pd = AUD_DACDAT;
            end
            chk("strobe_count", strobes.size(), 3);
            if (strobes.size() >= 3) begin
               chk("strobe_first", strobes[0], 2047);
               chk("strobe_second", strobes[1], 4095);
               chk("strobe_third", strobes[2], 6143);
            end
            chk("mclk_period_min", mmin, 8);
            chk("mclk_period_max", mmax, 8);
            chk("bclk_period_min", bmin, 32);
            chk("bclk_period_max", bmax, 32);
            chk("frame_start_phase", phase_bad, 0);
            chk("dacdat_change_edge", viol, 0);
            chk("bclk_slots", nrise[1], 64);
            chk("frame2_data", dat[1], exp_frame(16'h8001, 16'h7FFE));
            chk("frame3_data", dat[2], exp_frame(16'h1234, 16'h4321));
            chk("frame2_lrclk", lr[1], 64'hFFFFFFFF_00000000);
         end
         begin
            for (int k = 0; k < 13; k++)
               run_req(tbl[k].ch, tbl[k].a, tbl[k].wt, tbl[k].rv, tbl[k].lt, tbl[k].hold, CACHE && tbl[k].hit);
         end
      join
      @(negedge clock);
      v0 = valid_cnt;
      wait_cnt = 0; late = 0; rev = 0; req_cycles = 0; req_bad = 0;
      current_channel = 3'd4;
      mem_address = 26'h0000100;
      mem_request = 1'b1;
      seen = 0;
      for (int n = 0; n < 100 && !seen; n++) begin
         @(negedge clock);
         seen = busy && nbeat >= 5;
      end
      chk("fill_started", seen, 1);
      reset = 1'b1;
      mem_request = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      for (int n = 0; n < 100 && busy; n++) @(negedge clock);
      repeat (6) @(negedge clock);
      chk("abandoned_fill_valid", valid_cnt, v0);
      chk("abandoned_fill_req", sdram_request, 0);
      run_req(3'd0, 26'h0000040, 0, 0, 0, 0, 0);
      run_req(3'd4, 26'h0000100, 0, 1, 1, 0, 0);
      run_req(3'd4, 26'h0000113, 0, 0, 0, 0, CACHE);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
